pattern_executor: RTL and testbench

Consumer of the 4-bit mode code produced by the panel state decoder. Registers the code, decodes it into one of four operating modes, and drives an 8-bit LED bank with a timed pattern: a rotating one-hot chaser, a frozen pause, or a full-bank alert blink. A prescaler makes pattern steps visible at board clock rates. Sits between the state decoder and the LED pins.

---
 rtl/pattern_executor.sv | 115 +++++++++++
 tb/tb_pattern_executor.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pattern_executor.sv
// pattern_executor: decodes a registered 4-bit mode code into IDLE/RUN/PAUSE/ALERT and
//   drives an 8-bit LED bank (one-hot chaser, frozen pause, full-bank alert blink).
// Latency: 2 edges from state change to mode/entry led; all outputs registered.
// Backpressure: none; the input is sampled every cycle and every change is honoured in order.
// Ports: clk, rst (async, active-high), state[3:0] in; led[7:0], mode[1:0] out.
module pattern_executor #(
   parameter int TICK_DIV = 25000000,  // slow-step period in cycles (multiple of 4, >= 4)
   parameter int CNT_W    = 25         // prescaler width, 2^CNT_W > TICK_DIV
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] state,
   output logic [7:0] led,
   output logic [1:0] mode
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      ALERT = 2'b11
   } mode_t;

   localparam logic [CNT_W-1:0] LIM_SLOW = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] LIM_FAST = CNT_W'(TICK_DIV / 4 - 1);

   mode_t            cur;
   mode_t            nxt;
   logic [3:0]       state_q;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] limit;
   logic [7:0]       led_nxt;
   logic             step;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= 4'b0000;
         cur     <= IDLE;
         led     <= 8'h00;
         cnt     <= '0;
      end else begin
         state_q <= state;
         cur     <= nxt;
         led     <= led_nxt;
         cnt     <= cnt_nxt;
      end
   end

   always_comb begin
      nxt     = RUN;
      led_nxt = led;
      cnt_nxt = cnt;

      if (state_q[3])
         nxt = ALERT;
      else if (state_q == 4'b0000)
         nxt = IDLE;
      else if (state_q[1])
         nxt = PAUSE;

      limit = state_q[2] ? LIM_FAST : LIM_SLOW;
      // >= so that a slow-to-fast switch with cnt already past the new limit steps at once
      step  = (cnt >= limit);

      if (nxt != cur) begin
         // entry actions happen on the transition edge itself
         case (nxt)
            IDLE: begin
               led_nxt = 8'h00;
               cnt_nxt = '0;
            end
            RUN: begin
               // resuming from PAUSE keeps the frozen pattern and partial count
               if (cur != PAUSE) begin
                  led_nxt = 8'h01;
                  cnt_nxt = '0;
               end
            end
            ALERT: begin
               led_nxt = 8'hFF;
               cnt_nxt = '0;
            end
            default: ;  // PAUSE entry freezes everything
         endcase
      end else begin
         case (cur)
            IDLE: begin
               led_nxt = 8'h00;
               cnt_nxt = '0;
            end
            RUN: begin
               if (step) begin
                  cnt_nxt = '0;
                  led_nxt = state_q[0] ? {led[0], led[7:1]} : {led[6:0], led[7]};
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            ALERT: begin
               if (step) begin
                  cnt_nxt = '0;
                  led_nxt = ~led;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            default: ;  // PAUSE holds led and cnt
         endcase
      end
   end

   assign mode = cur;

endmodule

// File: tb/tb_pattern_executor.sv
// tb_pattern_executor: scoreboard bench for pattern_executor with TICK_DIV = 8.
// Each driven cycle pushes the expected {mode, led} seen just after the next rising edge;
// a monitor pops and compares one entry per cycle.
module tb_pattern_executor;

   logic       clk;
   logic       rst;
   logic [3:0] state;
   logic [7:0] led;
   logic [1:0] mode;

   int n_cmp = 0;
   int n_bad = 0;

   logic [9:0] exp_q[$];
   string      tag_q[$];

   pattern_executor #(.TICK_DIV(8), .CNT_W(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .state (state),
      .led   (led),
      .mode  (mode)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got mode=%0d led=%h, expected mode=%0d led=%h",
                  tag, obs[9:8], obs[7:0], exp_v[9:8], exp_v[7:0]);
      end
   endtask

   // drive one cycle of input and record the expected outputs after the coming edge
   task automatic cyc(input logic [3:0] s, input logic [1:0] m, input logic [7:0] l,
                      input string tag);
      @(negedge clk);
      state = s;
      exp_q.push_back({m, l});
      tag_q.push_back(tag);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            chk(tag_q.pop_front(), {mode, led}, exp_q.pop_front());
         end
      end
   end

   task automatic drain();
      int waited = 0;
      while (exp_q.size() != 0 && waited < 10) begin
         @(posedge clk);
         #2;
         waited++;
      end
      chk("drain", 10'(exp_q.size()), 10'd0);
   endtask

   logic [7:0] l;

   initial begin
      rst   = 1'b1;
      state = 4'b0000;
      @(posedge clk);
      #2;
      chk("reset", {mode, led}, 10'h000);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) cyc(4'b0000, 2'd0, 8'h00, "idle");

      // RUN fast left: entry two edges after the change, then a step every 2 cycles with wrap
      cyc(4'b0100, 2'd0, 8'h00, "run_latency");
      l = 8'h01;
      for (int i = 0; i < 10; i++) begin
         cyc(4'b0100, 2'd1, l, "run_fast_left");
         cyc(4'b0100, 2'd1, l, "run_fast_left");
         l = {l[6:0], l[7]};
      end
      cyc(4'b0000, 2'd1, 8'h04, "run_tail_step");
      cyc(4'b0001, 2'd0, 8'h00, "back_to_idle");

      // RUN slow right from 0x01
      l = 8'h01;
      for (int j = 0; j < 2; j++) begin
         repeat (8) cyc(4'b0001, 2'd1, l, "run_slow_right");
         l = {l[0], l[7:1]};
      end
      repeat (3) cyc(4'b0001, 2'd1, 8'h40, "run_slow_right");

      // PAUSE with cnt = 3 held, then resume after the remaining count
      cyc(4'b0011, 2'd1, 8'h40, "pause_latency");
      repeat (40) cyc(4'b0011, 2'd2, 8'h40, "pause_hold");
      cyc(4'b0001, 2'd2, 8'h40, "resume_latency");
      repeat (5) cyc(4'b0001, 2'd1, 8'h40, "resume_held");
      cyc(4'b0001, 2'd1, 8'h20, "resume_step");

      // slow with cnt = 6, then switch to fast: step on the edge after state_q updates
      repeat (6) cyc(4'b0001, 2'd1, 8'h20, "slow_count");
      cyc(4'b0101, 2'd1, 8'h20, "fast_latency");
      cyc(4'b0101, 2'd1, 8'h10, "fast_switch_step");
      cyc(4'b0101, 2'd1, 8'h10, "fast_after");
      repeat (2) cyc(4'b0101, 2'd1, 8'h08, "fast_after");
      repeat (2) cyc(4'b0101, 2'd1, 8'h04, "fast_after");

      // single-cycle alert pulse during RUN
      cyc(4'b1000, 2'd1, 8'h02, "pulse_latency");
      cyc(4'b0101, 2'd3, 8'hFF, "pulse_alert");
      cyc(4'b0101, 2'd1, 8'h01, "pulse_rerun");
      cyc(4'b0101, 2'd1, 8'h01, "pulse_rerun");
      repeat (2) cyc(4'b0101, 2'd1, 8'h80, "pulse_rerun_step");

      // ALERT from RUN: blink with slow period
      cyc(4'b1000, 2'd1, 8'h40, "alert_latency");
      repeat (8) cyc(4'b1000, 2'd3, 8'hFF, "alert_on");
      repeat (8) cyc(4'b1000, 2'd3, 8'h00, "alert_off");
      repeat (2) cyc(4'b1000, 2'd3, 8'hFF, "alert_on2");
      cyc(4'b0000, 2'd3, 8'hFF, "alert_exit_latency");
      repeat (3) cyc(4'b0000, 2'd0, 8'h00, "alert_to_idle");

      // IDLE -> PAUSE -> RUN gives a dark chaser
      cyc(4'b0010, 2'd0, 8'h00, "idle_pause_latency");
      cyc(4'b0001, 2'd2, 8'h00, "idle_pause");
      repeat (11) cyc(4'b0001, 2'd1, 8'h00, "dark_run");
      cyc(4'b0000, 2'd1, 8'h00, "dark_exit_latency");
      cyc(4'b0000, 2'd0, 8'h00, "dark_to_idle");

      // asynchronous reset mid-run
      cyc(4'b0100, 2'd0, 8'h00, "rerun_latency");
      cyc(4'b0100, 2'd1, 8'h01, "rerun");
      cyc(4'b0100, 2'd1, 8'h01, "rerun");
      cyc(4'b0100, 2'd1, 8'h02, "rerun_step");
      drain();
      rst   = 1'b1;
      state = 4'b0000;
      #1;
      chk("async_reset", {mode, led}, 10'h000);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (50) cyc(4'b0000, 2'd0, 8'h00, "post_reset_idle");
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
